csr_access_unit: RTL and testbench
==================================

# csr_access_unit

Sequencer that executes Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms) against the CSR file. It sits beside the execute stage: it accepts one decoded CSR request, reads the target CSR, computes the new value, issues the write, and returns the old value for rd. It is the initiator side of the CSR file's read/write port, and it defers to the trap and mret paths.

## Interface
- No parameters.
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- reqValid  in  1  CSR request present
- reqReady  out  1  unit idle, request accepted when reqValid && reqReady
- reqFunct3  in  3  instruction funct3
- reqAddress  in  12  CSR address
- reqOperand  in  32  rs1 value, or zero-extended zimm (selected upstream)
- reqSourceZero  in  1  rs1 index / zimm field is zero
- respValid  out  1  result available
- respReady  in  1  consumer takes result
- respData  out  32  old CSR value (rd writeback)
- respIllegal  out  1  illegal-instruction outcome
- readCSR  out  destinationCSR_  CSR file read index
- csrReadData  in  32  CSR file combinational read data
- destinationCSR  out  destinationCSR_  CSR file write index
- csrWriteData  out  32  write data
- csrDestinationEnable  out  1  write strobe, one cycle
- controlReset  in  1  trap flush
- mretSignal  in  1  mret in progress

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: reqReady=1. On accept, latch funct3, operand, reqSourceZero, decoded index, and the legality/ro flags. Go to READ.
- Decode: csrAddressDecode maps 0x300 MSTATUS, 0x301 MISA, 0x304 MIE, 0x305 MTVEC, 0x340 MSCRATCH, 0x341 MEPC, 0x342 MCAUSE, 0x343 MTVAL, 0x344 MIP, 0xB00 MCYCLE, 0xB02 MINSTRET. 0xF11–0xF14 are read-only zero (no file access). Any other address is unmapped.
- Op select: funct3[1:0] 01 = RW, 10 = RS, 11 = RC. funct3 000 or 100 is illegal.
- Write intent: RW always writes. RS/RC write only if !reqSourceZero.
- Illegal: unmapped address, bad funct3, or write intent to a read-only-zero address.
- READ: drive readCSR = index. Capture old = csrReadData, or 0 for read-only-zero. Compute new value in 32 bits:
  - RW: operand
  - RS: old | operand
  - RC: old & ~operand
  - Next state: WRITE if write intent and legal, else RESP.
- WRITE: drive csrDestinationEnable=1, destinationCSR=index, csrWriteData=new. If mretSignal=1 this cycle, the CSR file drops the write, so stay in WRITE and re-assert next cycle. Otherwise go to RESP.
- RESP: respValid=1, respData=old, respIllegal=flag. respData is 0 when illegal. Hold all three until respReady, then go to IDLE.
- controlReset in any non-IDLE state: abort to IDLE. No write, no response. A request offered in the same cycle as controlReset is not accepted.
- At most one write per request.

## Timing
- Reset values: state IDLE; respValid, respIllegal, csrDestinationEnable, respData, csrWriteData = 0; readCSR, destinationCSR = encoding 0. reqReady=1 in the first cycle after reset.
- Accept at cycle 0, READ cycle 1, WRITE cycle 2, respValid cycle 3 (with respReady=1, back to IDLE cycle 4).
- No-write or illegal path: respValid at cycle 2.
- Each mretSignal cycle during WRITE adds one cycle.
- Outputs are registered state decodes. csrWriteData is stable for the whole WRITE state.
- Throughput: one request per 4 cycles (3 cycles on the no-write path).

## Structure
- StaticPack: destinationCSR_ (existing), csrOp_ enum (RW/RS/RC), csrState_ enum, CSR address localparams, and the function csrAddressDecode returning {index, mapped, readOnlyZero}.
- One combinational sub-module is natural: csr_write_compute (op, old, operand -> new).
- Target size: ~150–200 lines RTL.

## Test plan
- MSCRATCH=0, CSRRW 0x340 operand 0xDEADBEEF -> cycle 2: enable, MSCRATCH index, data 0xDEADBEEF; cycle 3: respData 0x00000000, respIllegal 0.
- MSTATUS=0x00001800, CSRRS 0x300 operand 0x8 -> write 0x00001808; respData 0x00001800.
- CSRRC 0x341 with reqSourceZero=1 (MEPC=0x80000010) -> no enable ever; respValid at cycle 2 with 0x80000010.
- CSRRS 0xF14 with reqSourceZero=1 -> respData 0, legal. CSRRW 0xF14 -> respIllegal 1, no write. CSRRW 0x7C0 -> respIllegal 1.
- mretSignal high during the first WRITE cycle -> enable asserted 2 cycles total; respValid at cycle 4.
- controlReset during WRITE -> no further enable, respValid stays 0, reqReady=1 next cycle. respReady held low 5 cycles in RESP -> respValid/respData stable until the handshake.

Source files
------------

// File: rtl/csr_access_unit_pkg.sv
// Shared types for the CSR access unit.
//   destinationCSR_ : CSR file index encoding (read and write port index)
//   csrOp_          : Zicsr operation taken from funct3[1:0]
//   csrState_       : sequencer states
//   csrAddressDecode: CSR address -> {index, mapped, readOnlyZero}
package csr_access_unit_pkg;

    typedef enum logic [3:0] {
        CSR_MSTATUS  = 4'd0,
        CSR_MISA     = 4'd1,
        CSR_MIE      = 4'd2,
        CSR_MTVEC    = 4'd3,
        CSR_MSCRATCH = 4'd4,
        CSR_MEPC     = 4'd5,
        CSR_MCAUSE   = 4'd6,
        CSR_MTVAL    = 4'd7,
        CSR_MIP      = 4'd8,
        CSR_MCYCLE   = 4'd9,
        CSR_MINSTRET = 4'd10
    } destinationCSR_;

    // OP_NONE is the funct3[1:0] == 00 pattern, which is never a legal CSR op.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csrOp_;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } csrState_;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MISA     = 12'h301;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_RO_FIRST = 12'hF11;
    localparam logic [11:0] ADDR_RO_LAST  = 12'hF14;

    typedef struct packed {
        destinationCSR_ index;
        logic           mapped;
        logic           readOnlyZero;
    } csr_decode_t;

    // Read-only-zero addresses count as mapped but never touch the CSR file.
    function automatic csr_decode_t csrAddressDecode(input logic [11:0] address);
        csr_decode_t result;
        result.index        = CSR_MSTATUS;
        result.mapped       = 1'b1;
        result.readOnlyZero = 1'b0;
        case (address)
            ADDR_MSTATUS:  result.index = CSR_MSTATUS;
            ADDR_MISA:     result.index = CSR_MISA;
            ADDR_MIE:      result.index = CSR_MIE;
            ADDR_MTVEC:    result.index = CSR_MTVEC;
            ADDR_MSCRATCH: result.index = CSR_MSCRATCH;
            ADDR_MEPC:     result.index = CSR_MEPC;
            ADDR_MCAUSE:   result.index = CSR_MCAUSE;
            ADDR_MTVAL:    result.index = CSR_MTVAL;
            ADDR_MIP:      result.index = CSR_MIP;
            ADDR_MCYCLE:   result.index = CSR_MCYCLE;
            ADDR_MINSTRET: result.index = CSR_MINSTRET;
            default: begin
                if (address >= ADDR_RO_FIRST && address <= ADDR_RO_LAST) begin
                    result.readOnlyZero = 1'b1;
                end else begin
                    result.mapped = 1'b0;
                end
            end
        endcase
        return result;
    endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Request/response bus of the CSR access unit.
//   master : the execute stage issuing CSR requests and taking results
//   slave  : the CSR access unit
interface csr_access_unit_if;
    logic        reqValid;
    logic        reqReady;
    logic [2:0]  reqFunct3;
    logic [11:0] reqAddress;
    logic [31:0] reqOperand;
    logic        reqSourceZero;
    logic        respValid;
    logic        respReady;
    logic [31:0] respData;
    logic        respIllegal;

    modport master (
        output reqValid, reqFunct3, reqAddress, reqOperand, reqSourceZero, respReady,
        input  reqReady, respValid, respData, respIllegal
    );

    modport slave (
        input  reqValid, reqFunct3, reqAddress, reqOperand, reqSourceZero, respReady,
        output reqReady, respValid, respData, respIllegal
    );
endinterface

// File: rtl/csr_access_unit_write_compute.sv
// Combinational new-value computation for Zicsr ops.
//   op        : RW / RS / RC
//   old_value : current CSR value
//   operand   : rs1 value or zero-extended zimm
//   new_value : RW -> operand, RS -> old | operand, RC -> old & ~operand
module csr_access_unit_write_compute
    import csr_access_unit_pkg::*;
(
    input  csrOp_       op,
    input  logic [31:0] old_value,
    input  logic [31:0] operand,
    output logic [31:0] new_value
);

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_bit
            assign new_value[gi] = (op == OP_RS) ? (old_value[gi] | operand[gi]) :
                                   (op == OP_RC) ? (old_value[gi] & ~operand[gi]) :
                                                   operand[gi];
        end
    endgenerate

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr sequencer: accepts one decoded CSR request, reads the CSR, computes
// the new value, issues at most one write and returns the old value.
//   clock, reset         : clock and synchronous active-high reset
//   bus (slave)          : request/response handshake
//   readCSR/csrReadData  : CSR file combinational read port
//   destinationCSR, csrWriteData, csrDestinationEnable : CSR file write port
//   controlReset         : trap flush, aborts any request in flight
//   mretSignal           : mret in progress, CSR file drops writes this cycle
module csr_access_unit
    import csr_access_unit_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    csr_access_unit_if.slave    bus,
    output destinationCSR_      readCSR,
    input  logic [31:0]         csrReadData,
    output destinationCSR_      destinationCSR,
    output logic [31:0]         csrWriteData,
    output logic                csrDestinationEnable,
    input  logic                controlReset,
    input  logic                mretSignal
);

    csrState_       state_reg, state_next;
    csrOp_          op_reg;
    logic [31:0]    operand_reg;
    logic           source_zero_reg;
    destinationCSR_ index_reg;
    logic           illegal_reg;
    logic           read_only_zero_reg;
    logic [31:0]    old_reg;
    logic [31:0]    new_reg;

    csr_decode_t    req_decode;
    csrOp_          req_op;
    logic           req_write_intent;
    logic           req_illegal;
    logic           accept;
    logic           write_intent;
    logic [31:0]    read_value;
    logic [31:0]    new_value;

    // Request decode, used only at the accept edge.
    always_comb begin
        req_decode       = csrAddressDecode(bus.reqAddress);
        req_op           = csrOp_'(bus.reqFunct3[1:0]);
        req_write_intent = (req_op == OP_RW) || !bus.reqSourceZero;
        req_illegal      = !req_decode.mapped
                        || (bus.reqFunct3 == 3'b000) || (bus.reqFunct3 == 3'b100)
                        || (req_decode.readOnlyZero && req_write_intent);
    end

    // A flush in the same cycle as an offered request blocks the handshake.
    assign bus.reqReady = (state_reg == ST_IDLE) && !controlReset;
    assign accept       = bus.reqValid && bus.reqReady;

    assign write_intent = (op_reg == OP_RW) || !source_zero_reg;
    assign read_value   = read_only_zero_reg ? 32'h0 : csrReadData;

    csr_access_unit_write_compute u_write_compute (
        .op        (op_reg),
        .old_value (read_value),
        .operand   (operand_reg),
        .new_value (new_value)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_READ;
            end
            ST_READ: begin
                if (controlReset)                     state_next = ST_IDLE;
                else if (write_intent && !illegal_reg) state_next = ST_WRITE;
                else                                  state_next = ST_RESP;
            end
            ST_WRITE: begin
                // A write landing under mret is dropped by the CSR file; retry.
                if (controlReset)     state_next = ST_IDLE;
                else if (!mretSignal) state_next = ST_RESP;
            end
            ST_RESP: begin
                if (controlReset)       state_next = ST_IDLE;
                else if (bus.respReady) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_reg             <= OP_NONE;
            operand_reg        <= 32'h0;
            source_zero_reg    <= 1'b0;
            index_reg          <= CSR_MSTATUS;
            illegal_reg        <= 1'b0;
            read_only_zero_reg <= 1'b0;
            old_reg            <= 32'h0;
            new_reg            <= 32'h0;
        end else begin
            if (accept) begin
                op_reg             <= req_op;
                operand_reg        <= bus.reqOperand;
                source_zero_reg    <= bus.reqSourceZero;
                index_reg          <= req_decode.index;
                illegal_reg        <= req_illegal;
                read_only_zero_reg <= req_decode.readOnlyZero;
            end
            // new_reg only changes in READ, so the write data is steady across WRITE.
            if (state_reg == ST_READ) begin
                old_reg <= illegal_reg ? 32'h0 : read_value;
                new_reg <= new_value;
            end
        end
    end

    assign readCSR              = index_reg;
    assign destinationCSR       = index_reg;
    assign csrWriteData         = new_reg;
    assign csrDestinationEnable = (state_reg == ST_WRITE);
    assign bus.respValid        = (state_reg == ST_RESP);
    assign bus.respData         = old_reg;
    assign bus.respIllegal      = (state_reg == ST_RESP) && illegal_reg;

endmodule

// File: tb/tb_csr_access_unit.sv
module tb_csr_access_unit;
    import csr_access_unit_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    csr_access_unit_if bus();

    destinationCSR_ readCSR;
    destinationCSR_ destinationCSR;
    logic [31:0]    csrReadData;
    logic [31:0]    csrWriteData;
    logic           csrDestinationEnable;
    logic           controlReset = 1'b0;
    logic           mretSignal;
    logic           mret_rand = 1'b0;
    logic           mret_forced = 1'b0;
    assign mretSignal = mret_rand | mret_forced;

    csr_access_unit dut (
        .clock                (clock),
        .reset                (reset),
        .bus                  (bus),
        .readCSR              (readCSR),
        .csrReadData          (csrReadData),
        .destinationCSR       (destinationCSR),
        .csrWriteData         (csrWriteData),
        .csrDestinationEnable (csrDestinationEnable),
        .controlReset         (controlReset),
        .mretSignal           (mretSignal)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- CSR file environment ----------------
    logic [31:0] env_file [0:15];
    int          txn_lat;
    int          txn_wr_cnt;
    int          txn_mret;
    logic [31:0] txn_wr_data;
    assign csrReadData = env_file[readCSR];

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) env_file[i] <= 32'h0;
            txn_lat <= 0; txn_wr_cnt <= 0; txn_mret <= 0; txn_wr_data <= 32'h0;
        end else if (bus.reqValid && bus.reqReady) begin
            txn_lat <= 0; txn_wr_cnt <= 0; txn_mret <= 0;
        end else begin
            txn_lat <= txn_lat + 1;
            // The file drops writes under mret and under a trap flush.
            if (csrDestinationEnable && !controlReset) begin
                if (mretSignal) txn_mret <= txn_mret + 1;
                else begin
                    env_file[destinationCSR] <= csrWriteData;
                    txn_wr_cnt  <= txn_wr_cnt + 1;
                    txn_wr_data <= csrWriteData;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        logic        illegal;
        int          wr_cnt;
        logic [31:0] wr_data;
        int          base_lat;
    } exp_t;

    exp_t sb_q[$];
    bit [31:0] model_mem [bit [11:0]];

    function automatic exp_t model_step(input logic [2:0] f3, input logic [11:0] addr,
                                        input logic [31:0] operand, input logic sz);
        exp_t e;
        bit mapped, roz, wr;
        int op;
        bit [31:0] old, nv;
        mapped = addr inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                              12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02};
        roz    = addr inside {[12'hF11:12'hF14]};
        op     = int'(f3) % 4;
        wr     = (op == 1) || !sz;
        e.illegal = (!mapped && !roz) || (op == 0) || (roz && wr);
        old = roz ? 32'h0 : (model_mem.exists(addr) ? model_mem[addr] : 32'h0);
        e.data = e.illegal ? 32'h0 : old;
        e.wr_cnt = 0; e.wr_data = 32'h0; e.base_lat = 2;
        if (!e.illegal && wr) begin
            case (op)
                1:       nv = operand;
                2:       nv = old | operand;
                default: nv = old & ~operand;
            endcase
            model_mem[addr] = nv;
            e.wr_cnt = 1; e.wr_data = nv; e.base_lat = 3;
        end
        return e;
    endfunction

    // ---------------- drivers ----------------
    int  bp_mode = 0;   // 0 always ready, 1 random stalls, 2 hold low
    bit  mret_en = 1'b0;
    int  stall_cnt = 0;

    initial begin
        bus.respReady = 1'b1;
        forever begin
            @(negedge clock);
            if (bp_mode == 2) bus.respReady = 1'b0;
            else if (bp_mode == 0) bus.respReady = 1'b1;
            else if (stall_cnt > 0) begin
                bus.respReady = 1'b0; stall_cnt--;
            end else if ($urandom_range(0, 3) == 0) begin
                bus.respReady = 1'b0; stall_cnt = $urandom_range(0, 4);
            end else bus.respReady = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            mret_rand = mret_en ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit prev_valid = 0, prev_ready = 0, prev_ill = 0;
        logic [31:0] prev_data = 0;
        int n_txn = 0;
        exp_t e;
        forever begin
            @(negedge clock); #1;
            if (reset) continue;
            if (prev_valid && !prev_ready) begin
                check("resp_hold_valid", {31'h0, bus.respValid}, 32'h1);
                check("resp_hold_data", bus.respData, prev_data);
                check("resp_hold_illegal", {31'h0, bus.respIllegal}, {31'h0, prev_ill});
            end
            if (bus.respValid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_resp_qsize", 32'h0, 32'h1);
                end else begin
                    if (!prev_valid)
                        check("resp_latency", txn_lat + 1, sb_q[0].base_lat + txn_mret);
                    if (bus.respReady) begin
                        e = sb_q.pop_front();
                        n_txn++;
                        $display("txn %0d respData=%h respIllegal=%b writes=%0d",
                                 n_txn, bus.respData, bus.respIllegal, txn_wr_cnt);
                        check("resp_data", bus.respData, e.data);
                        check("resp_illegal", {31'h0, bus.respIllegal}, {31'h0, e.illegal});
                        check("write_count", txn_wr_cnt, e.wr_cnt);
                        if (e.wr_cnt == 1) check("write_data", txn_wr_data, e.wr_data);
                    end
                end
            end
            prev_valid = bus.respValid;
            prev_ready = bus.respReady;
            prev_data  = bus.respData;
            prev_ill   = bus.respIllegal;
        end
    end

    // ---------------- stimulus ----------------
    // abort_at: 0 none, 1 flush in READ cycle, 2 flush in WRITE cycle.
    task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] operand,
                         input logic sz, input int abort_at, input bit mret_first);
        int n = 0;
        @(negedge clock);
        bus.reqValid = 1'b1; bus.reqFunct3 = f3; bus.reqAddress = addr;
        bus.reqOperand = operand; bus.reqSourceZero = sz;
        #1;
        while (!bus.reqReady) begin
            @(negedge clock); #1;
            n++;
            if (n > 100) begin
                check("req_ready_timeout", 32'h0, 32'h1);
                bus.reqValid = 1'b0;
                return;
            end
        end
        if (abort_at == 0) sb_q.push_back(model_step(f3, addr, operand, sz));
        @(posedge clock);
        @(negedge clock);
        bus.reqValid = 1'b0;
        if (abort_at == 1) controlReset = 1'b1;
        @(negedge clock);
        controlReset = 1'b0;
        if (abort_at == 2) controlReset = 1'b1;
        if (mret_first) mret_forced = 1'b1;
        @(negedge clock);
        controlReset = 1'b0;
        mret_forced = 1'b0;
        #1;
        if (abort_at == 2) begin
            check("abort_enable", {31'h0, csrDestinationEnable}, 32'h0);
            check("abort_respvalid", {31'h0, bus.respValid}, 32'h0);
            check("abort_reqready", {31'h0, bus.reqReady}, 32'h1);
        end
        if (mret_first) check("mret_reassert_enable", {31'h0, csrDestinationEnable}, 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] mapped_tab [11];
        logic [11:0] addr;
        logic [2:0]  f3;
        logic        sz;
        logic [31:0] opnd;
        int r, w;
        mapped_tab = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                       12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02};
        bus.reqValid = 1'b0; bus.reqFunct3 = 3'b0; bus.reqAddress = 12'h0;
        bus.reqOperand = 32'h0; bus.reqSourceZero = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset_reqready", {31'h0, bus.reqReady}, 32'h1);
        check("reset_respvalid", {31'h0, bus.respValid}, 32'h0);
        check("reset_respillegal", {31'h0, bus.respIllegal}, 32'h0);
        check("reset_enable", {31'h0, csrDestinationEnable}, 32'h0);
        check("reset_respdata", bus.respData, 32'h0);
        check("reset_wrdata", csrWriteData, 32'h0);
        check("reset_readcsr", {28'h0, readCSR}, 32'h0);
        check("reset_destcsr", {28'h0, destinationCSR}, 32'h0);

        // Directed cases.
        issue(3'b001, 12'h340, 32'hDEADBEEF, 1'b0, 0, 1'b0); // CSRRW MSCRATCH
        issue(3'b001, 12'h300, 32'h00001800, 1'b0, 0, 1'b0); // MSTATUS = 0x1800
        issue(3'b010, 12'h300, 32'h00000008, 1'b0, 0, 1'b0); // CSRRS -> 0x1808
        issue(3'b001, 12'h341, 32'h80000010, 1'b0, 0, 1'b0); // MEPC = 0x80000010
        issue(3'b011, 12'h341, 32'h0,        1'b1, 0, 1'b0); // CSRRC x0: no write
        issue(3'b010, 12'hF14, 32'h0,        1'b1, 0, 1'b0); // RO-zero read, legal
        issue(3'b001, 12'hF14, 32'h5,        1'b0, 0, 1'b0); // RO-zero write: illegal
        issue(3'b001, 12'h7C0, 32'h5,        1'b0, 0, 1'b0); // unmapped: illegal
        issue(3'b000, 12'h340, 32'h5,        1'b0, 0, 1'b0); // bad funct3
        issue(3'b100, 12'h340, 32'h5,        1'b0, 0, 1'b0); // bad funct3
        issue(3'b101, 12'h305, 32'h0000001F, 1'b0, 0, 1'b1); // mret in first WRITE
        issue(3'b001, 12'h342, 32'h0000000B, 1'b0, 2, 1'b0); // flush in WRITE
        issue(3'b010, 12'h342, 32'h0,        1'b1, 0, 1'b0); // MCAUSE still 0
        bp_mode = 2;
        issue(3'b001, 12'h343, 32'h12345678, 1'b0, 0, 1'b0); // held response
        repeat (5) @(negedge clock);
        bp_mode = 0;

        // Randomized phase.
        bp_mode = 1;
        mret_en = 1'b1;
        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      addr = mapped_tab[$urandom_range(0, 10)];
            else if (r < 8) addr = 12'hF11 + 12'($urandom_range(0, 3));
            else if (r < 9) addr = 12'h7C0;
            else            addr = 12'($urandom_range(0, 4095));
            f3   = 3'($urandom_range(0, 7));
            sz   = ($urandom_range(0, 3) == 0);
            opnd = sz ? 32'h0 : $urandom;
            issue(f3, addr, opnd, sz, ($urandom_range(0, 9) == 0) ? 1 : 0, 1'b0);
        end

        w = 0;
        while (sb_q.size() != 0 && w < 200) begin
            @(negedge clock);
            w++;
        end
        check("scoreboard_drained", sb_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
